uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised successor to the UART receiver. Supports runtime-selectable data length, parity mode and 1 or 2 stop bits, and uses 3-sample majority voting. Received words are buffered in a small FIFO with a valid/ready output handshake, so a slow consumer does not lose frames. It sits between the serial pin and the system-side byte consumer, in the same place as the existing receiver.

Parameters:
MAX_WIDTH, 9, maximum data bits per frame; sets P_Data width.
FIFO_DEPTH, 4, number of buffered words; must be a power of 2 and at least 2.

Ports:
Clk  in  1  system clock; all logic is rising-edge.
Rst  in  1  reset; synchronous, active-high.
Rx_in  in  1  asynchronous serial line; idle is high.
Prescale  in  6  oversampling ratio; legal values are even and 8..32.
Data_Len  in  4  data bits per frame; legal range 5..MAX_WIDTH.
Parity_En  in  1  1 = parity bit present.
Parity_Typ  in  1  0 = even, 1 = odd.
Stop_Bits  in  1  0 = one stop bit, 1 = two stop bits.
P_Data  out  MAX_WIDTH  FIFO head word, right-justified, unused MSBs 0.
Data_Valid  out  1  FIFO non-empty.
Data_Ready  in  1  consumer accepts the head word when Data_Valid & Data_Ready.
Parity_Err  out  1  parity error flag of the head word; meaningful only while Data_Valid.
Framing_Err  out  1  stop-bit error flag of the head word; meaningful only while Data_Valid.
Overrun_Err  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
Break_Det  out  1  one-cycle pulse: a frame with every sampled bit 0 was received.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - All outputs go to 0 and the FIFO empties.
  - FSM goes to IDLE; counters clear.
  - Both synchroniser flops load 1.
  - Reset mid-frame discards the partial frame with no pulses.
- Input path: 2-flop synchroniser on Rx_in; rx_s is its output. Start detection uses rx_s 1->0 while IDLE.
- Counters:
  - edge_cnt runs 0..Prescale-1 and wraps.
  - bit_cnt increments on each edge_cnt wrap.
- Sampling: rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1 (P = Prescale). The bit value is the majority of the three, resolved in the cycle edge_cnt = P/2+1.
- Config capture: Data_Len, Parity_En, Parity_Typ and Stop_Bits are latched on the start edge. Changes during a frame take effect on the next frame only.
- FSM states and transitions:
  - IDLE -> START on the falling edge of rx_s; edge_cnt starts at 0.
  - START: if the majority value is 1, it is a glitch -> IDLE with no output. Otherwise -> DATA at the bit boundary.
  - DATA: shift in LSB-first, Data_Len bits. Then -> PARITY if Parity_En=1, else -> STOP.
  - PARITY: compute the XOR of the data bits plus the parity bit. Parity error = (XOR != Parity_Typ) for even/odd.
  - STOP: sample 1 or 2 stop bits. Any stop bit sampled 0 sets Framing_Err for that word.
- End of frame: in the cycle the final stop-bit majority resolves:
  - the word and its flags are written to the FIFO;
  - the FSM returns to IDLE immediately, so a new start edge is accepted in the second half of the stop bit (back-to-back frames).
- Break_Det: pulses in the cycle after the final stop-bit resolve when all data, parity and stop samples were 0. The word (0) is still written with Framing_Err=1.
- FIFO:
  - Each entry holds data, Parity_Err and Framing_Err.
  - Write latency: Data_Valid and P_Data are visible the cycle after the write.
  - A pop on Data_Valid & Data_Ready advances the head next cycle.
  - Full with no pop at write: the new frame is dropped, the FIFO is unchanged, and Overrun_Err pulses one cycle.
  - Full with a simultaneous pop and write: the pop and write both occur, with no overrun.
  - Empty with a write and Data_Ready=1: not a pass-through; the word appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
- Illegal Prescale or Data_Len values give unspecified data but must not lock up the FSM. The FSM must return to IDLE within one frame time.

Test Plan:
- Prescale=8, 8N1, Data_Ready=1, send 0xA5 -> Data_Valid high for 1 cycle, P_Data=0x0A5, Parity_Err=0, Framing_Err=0.
- Prescale=16, Data_Len=7, even parity, send 0x55 with wrong parity bit 1 -> P_Data=0x055, Parity_Err=1. Repeat with Parity_Typ=1 -> Parity_Err=0.
- Stop_Bits=1, second stop bit driven 0 -> Framing_Err=1 with correct data. Then drive the line low for a whole frame -> Break_Det pulse, P_Data=0, Framing_Err=1.
- Start glitch: Rx_in low for 2 of 8 cycles -> FSM back to IDLE, no write; the following valid frame 0x3C is received intact.
- Data_Ready=0, send 5 back-to-back frames 0x01..0x05 (FIFO_DEPTH=4) -> Overrun_Err pulses once, on the 5th frame. Raise Data_Ready -> pops 0x01, 0x02, 0x03, 0x04 in order, then Data_Valid=0.
- Assert Rst in the middle of DATA of frame 0x99 -> no outputs asserted. The next frame 0x66 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with runtime frame format,
// 3-sample majority voting and a small word FIFO toward the consumer.
module uart_rx_fifo #(
    parameter int MAX_WIDTH  = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx_in,
    input  logic [5:0]           Prescale,
    input  logic [3:0]           Data_Len,
    input  logic                 Parity_En,
    input  logic                 Parity_Typ,
    input  logic                 Stop_Bits,
    output logic [MAX_WIDTH-1:0] P_Data,
    output logic                 Data_Valid,
    input  logic                 Data_Ready,
    output logic                 Parity_Err,
    output logic                 Framing_Err,
    output logic                 Overrun_Err,
    output logic                 Break_Det
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = MAX_WIDTH + 2;
    localparam logic [3:0] MAX_LEN = 4'(MAX_WIDTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                 sync1, rx_s, rx_d;
    logic [2:0]           state;
    logic [5:0]           edge_cnt;
    logic [3:0]           bit_cnt;
    logic [5:0]           cfg_pre;
    logic [3:0]           cfg_len;
    logic                 cfg_par_en, cfg_par_typ, cfg_stop2;
    logic                 s0, s1;
    logic [MAX_WIDTH-1:0] shift;
    logic                 par_err, frm_err, all_zero;

    logic [5:0] pre_eff, half;
    logic [3:0] len_eff;
    logic       at_s0, at_s1, at_res, at_wrap, maj;
    logic       start_fall, last_stop;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, push;
    logic [EW-1:0] head;

    // Illegal rates/lengths are clamped so every bit period ends and
    // every sample point is reachable; the FSM can never stall.
    assign pre_eff = (Prescale < 6'd8) ? 6'd8 : Prescale;
    assign len_eff = (Data_Len == 4'd0) ? 4'd1 :
                     (Data_Len > MAX_LEN) ? MAX_LEN : Data_Len;

    assign half    = cfg_pre >> 1;
    assign at_s0   = (edge_cnt == half - 6'd1);
    assign at_s1   = (edge_cnt == half);
    assign at_res  = (edge_cnt == half + 6'd1);
    assign at_wrap = (edge_cnt >= cfg_pre - 6'd1);
    assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    assign start_fall = (state == IDLE) && rx_d && !rx_s;
    assign last_stop  = (state == STOP) && at_res &&
                        (bit_cnt == {3'b000, cfg_stop2});

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && Data_Ready;
    assign push  = last_stop && (!full || pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign Data_Valid  = !empty;
    assign P_Data      = Data_Valid ? head[MAX_WIDTH-1:0] : '0;
    assign Parity_Err  = Data_Valid & head[MAX_WIDTH];
    assign Framing_Err = Data_Valid & head[MAX_WIDTH+1];

    // Two-flop synchroniser plus a delayed copy for falling-edge detect.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= Rx_in;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    // Frame FSM: timing counters, sampling, shift register and flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            cfg_pre     <= 6'd8;
            cfg_len     <= 4'd8;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= 1'b0;
            cfg_stop2   <= 1'b0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            shift       <= '0;
            par_err     <= 1'b0;
            frm_err     <= 1'b0;
            all_zero    <= 1'b0;
        end else if (state == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            if (start_fall) begin
                state       <= START;
                cfg_pre     <= pre_eff;
                cfg_len     <= len_eff;
                cfg_par_en  <= Parity_En;
                cfg_par_typ <= Parity_Typ;
                cfg_stop2   <= Stop_Bits;
                shift       <= '0;
                par_err     <= 1'b0;
                frm_err     <= 1'b0;
                all_zero    <= 1'b1;
            end
        end else begin
            edge_cnt <= at_wrap ? 6'd0 : edge_cnt + 6'd1;
            if (at_s0) s0 <= rx_s;
            if (at_s1) s1 <= rx_s;
            case (state)
                START: begin
                    if (at_res && maj) begin
                        state <= IDLE;
                    end else if (at_wrap) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (at_res) begin
                        if (bit_cnt < MAX_LEN) shift[bit_cnt] <= maj;
                        all_zero <= all_zero & ~maj;
                    end
                    if (at_wrap) begin
                        if (bit_cnt >= cfg_len - 4'd1) begin
                            bit_cnt <= '0;
                            state   <= cfg_par_en ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (at_res) begin
                        par_err  <= ((^shift) ^ maj) != cfg_par_typ;
                        all_zero <= all_zero & ~maj;
                    end
                    if (at_wrap) state <= STOP;
                end
                STOP: begin
                    if (at_res) begin
                        frm_err  <= frm_err | ~maj;
                        all_zero <= all_zero & ~maj;
                        if (last_stop) state <= IDLE;
                    end
                    if (at_wrap) bit_cnt <= bit_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; the slot under a simultaneous pop may be reused.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {frm_err | ~maj, par_err, shift};
    end

    // FIFO pointers and the one-cycle overrun / break pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            Overrun_Err <= 1'b0;
            Break_Det   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            Overrun_Err <= last_stop && full && !pop;
            Break_Det   <= last_stop && all_zero && !maj;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames with a scoreboard queue; a monitor
// pops and compares each word the receiver hands over.
module tb_uart_rx_fifo;
    localparam int MW = 9;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Rx_in;
    logic [5:0]    Prescale;
    logic [3:0]    Data_Len;
    logic          Parity_En;
    logic          Parity_Typ;
    logic          Stop_Bits;
    logic [MW-1:0] P_Data;
    logic          Data_Valid;
    logic          Data_Ready;
    logic          Parity_Err;
    logic          Framing_Err;
    logic          Overrun_Err;
    logic          Break_Det;

    typedef struct packed {
        logic [MW-1:0] data;
        logic          par;
        logic          frm;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    exp_t a_mon;
    int   vectors = 0;
    int   miscompares = 0;
    int   ovr_cnt = 0;
    int   brk_cnt = 0;
    int   valid_cycles = 0;

    uart_rx_fifo #(.MAX_WIDTH(MW), .FIFO_DEPTH(4)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Rx_in       (Rx_in),
        .Prescale    (Prescale),
        .Data_Len    (Data_Len),
        .Parity_En   (Parity_En),
        .Parity_Typ  (Parity_Typ),
        .Stop_Bits   (Stop_Bits),
        .P_Data      (P_Data),
        .Data_Valid  (Data_Valid),
        .Data_Ready  (Data_Ready),
        .Parity_Err  (Parity_Err),
        .Framing_Err (Framing_Err),
        .Overrun_Err (Overrun_Err),
        .Break_Det   (Break_Det)
    );

    always #5 Clk = ~Clk;

    // Monitor: counts pulses and checks every accepted word.
    always @(negedge Clk) begin
        if (Overrun_Err) ovr_cnt++;
        if (Break_Det) brk_cnt++;
        if (Data_Valid) valid_cycles++;
        if (Data_Valid && Data_Ready) begin
            vectors++;
            a_mon = '{data: P_Data, par: Parity_Err, frm: Framing_Err};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got data=%h par=%b frm=%b, required no word",
                         P_Data, Parity_Err, Framing_Err);
            end else begin
                e_mon = exp_q.pop_front();
                if (a_mon !== e_mon) begin
                    miscompares++;
                    $display("FAIL pop_word: got data=%h par=%b frm=%b, required data=%h par=%b frm=%b",
                             a_mon.data, a_mon.par, a_mon.frm,
                             e_mon.data, e_mon.par, e_mon.frm);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    task automatic drive_bit(input int pre, input logic b);
        Rx_in = b;
        repeat (pre) @(negedge Clk);
    endtask

    task automatic send_frame(input int pre, input int len,
                              input logic [MW-1:0] d,
                              input logic has_par, input logic par_bit,
                              input int nstop, input logic [1:0] stops);
        logic [MW-1:0] dv;
        logic [1:0]    sv;
        dv = d;
        sv = stops;
        drive_bit(pre, 1'b0);
        for (int i = 0; i < len; i++) drive_bit(pre, dv[i]);
        if (has_par) drive_bit(pre, par_bit);
        for (int i = 0; i < nstop; i++) drive_bit(pre, sv[i]);
    endtask

    task automatic idle(input int n);
        Rx_in = 1'b1;
        repeat (n) @(negedge Clk);
    endtask

    task automatic push_exp(input logic [MW-1:0] d, input logic p,
                            input logic f);
        exp_q.push_back('{data: d, par: p, frm: f});
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d words still pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int vc0, b0, o0;
        Rst        = 1'b1;
        Rx_in      = 1'b1;
        Data_Ready = 1'b0;
        Prescale   = 6'd8;
        Data_Len   = 4'd8;
        Parity_En  = 1'b0;
        Parity_Typ = 1'b0;
        Stop_Bits  = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_outputs",
              int'({Data_Valid, P_Data, Parity_Err, Framing_Err,
                    Overrun_Err, Break_Det}), 0);
        Rst = 1'b0;
        idle(5);
        check("post_reset_valid", int'(Data_Valid), 0);

        // 8N1 at Prescale 8, consumer always ready.
        Data_Ready = 1'b1;
        vc0 = valid_cycles;
        push_exp(9'h0A5, 1'b0, 1'b0);
        send_frame(8, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11);
        idle(20);
        check("valid_one_cycle", valid_cycles - vc0, 1);
        drain("drain_8n1", 50);

        // 7E1 with a wrong parity bit, then the same bits as 7O1.
        Prescale  = 6'd16;
        Data_Len  = 4'd7;
        Parity_En = 1'b1;
        push_exp(9'h055, 1'b1, 1'b0);
        send_frame(16, 7, 9'h055, 1'b1, 1'b1, 1, 2'b11);
        idle(40);
        Parity_Typ = 1'b1;
        push_exp(9'h055, 1'b0, 1'b0);
        send_frame(16, 7, 9'h055, 1'b1, 1'b1, 1, 2'b11);
        idle(40);
        drain("drain_parity", 80);

        // Two stop bits: bad second stop, then a full break frame.
        Prescale   = 6'd8;
        Data_Len   = 4'd8;
        Parity_En  = 1'b0;
        Parity_Typ = 1'b0;
        Stop_Bits  = 1'b1;
        b0 = brk_cnt;
        push_exp(9'h0C3, 1'b0, 1'b1);
        send_frame(8, 8, 9'h0C3, 1'b0, 1'b0, 2, 2'b01);
        idle(20);
        check("no_break_on_framing", brk_cnt - b0, 0);
        push_exp(9'h000, 1'b0, 1'b1);
        send_frame(8, 8, 9'h000, 1'b0, 1'b0, 2, 2'b00);
        idle(20);
        check("break_pulse", brk_cnt - b0, 1);
        drain("drain_stop", 50);

        // Short start glitch must be rejected without a write.
        Stop_Bits = 1'b0;
        Rx_in = 1'b0;
        repeat (2) @(negedge Clk);
        idle(30);
        check("glitch_no_word", int'(Data_Valid), 0);
        push_exp(9'h03C, 1'b0, 1'b0);
        send_frame(8, 8, 9'h03C, 1'b0, 1'b0, 1, 2'b11);
        idle(20);
        drain("drain_glitch", 50);

        // Five back-to-back frames into a stalled 4-entry FIFO.
        Data_Ready = 1'b0;
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) push_exp(MW'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            send_frame(8, 8, MW'(i), 1'b0, 1'b0, 1, 2'b11);
        idle(20);
        check("overrun_once", ovr_cnt - o0, 1);
        check("full_head_data", int'(P_Data), 1);
        check("full_valid", int'(Data_Valid), 1);
        Data_Ready = 1'b1;
        drain("drain_overrun", 50);
        repeat (2) @(negedge Clk);
        check("empty_after_drain", int'(Data_Valid), 0);

        // Reset in the middle of the data bits of 0x99.
        vc0 = valid_cycles;
        b0  = brk_cnt;
        o0  = ovr_cnt;
        drive_bit(8, 1'b0);
        drive_bit(8, 1'b1);
        drive_bit(8, 1'b0);
        drive_bit(8, 1'b0);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        idle(100);
        check("reset_mid_no_valid", valid_cycles - vc0, 0);
        check("reset_mid_no_pulse", (brk_cnt - b0) + (ovr_cnt - o0), 0);
        push_exp(9'h066, 1'b0, 1'b0);
        send_frame(8, 8, 9'h066, 1'b0, 1'b0, 1, 2'b11);
        idle(20);
        drain("drain_after_reset", 50);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
